// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - MMIO address map and default sizing for the UART receive FIFO
package uart_rx_fifo_pkg;

    localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;

    localparam int RX_FIFO_WIDTH = 8;
    localparam int RX_FIFO_DEPTH = 8;

    function automatic int count_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and MMIO-side handshake bundle of the UART receive FIFO
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = RX_FIFO_WIDTH,
    parameter int DEPTH = RX_FIFO_DEPTH
);
    logic [WIDTH-1:0]             data_enq_in;
    logic                         ctrl_enq_valid_in;
    logic                         ctrl_enq_ready_out;
    logic [WIDTH-1:0]             data_deq_out;
    logic                         ctrl_deq_valid_out;
    logic                         ctrl_deq_ready_in;
    logic [count_bits(DEPTH)-1:0] data_count_out;
    logic                         ctrl_overrun_out;

    modport slave (
        input  data_enq_in, ctrl_enq_valid_in, ctrl_deq_ready_in,
        output ctrl_enq_ready_out, data_deq_out, ctrl_deq_valid_out,
               data_count_out, ctrl_overrun_out
    );

    modport master (
        output data_enq_in, ctrl_enq_valid_in, ctrl_deq_ready_in,
        input  ctrl_enq_ready_out, data_deq_out, ctrl_deq_valid_out,
               data_count_out, ctrl_overrun_out
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through byte FIFO between the UART receiver and MMIO
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = RX_FIFO_WIDTH,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  io
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             enq_ready, deq_valid, enq, deq;

    // Ready depends only on registered occupancy, never on the MMIO-side ready.
    assign enq_ready = !rst && (count_q != FULL);
    assign deq_valid = !rst && (count_q != '0);
    assign enq       = io.ctrl_enq_valid_in && enq_ready;
    assign deq       = deq_valid && io.ctrl_deq_ready_in;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
        if (io.ctrl_enq_valid_in && (count_q == FULL)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately left unreset; enq is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= io.data_enq_in;
        end
    end

    assign io.ctrl_enq_ready_out = enq_ready;
    assign io.ctrl_deq_valid_out = deq_valid;
    assign io.data_deq_out       = mem_q[rd_ptr_q];
    assign io.data_count_out     = rst ? '0 : count_q;
    assign io.ctrl_overrun_out   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with directed and random traffic
module tb_uart_rx_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    uart_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dif ();

    uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain byte queue plus occupancy and a sticky overrun flag.
    logic [WIDTH-1:0] exp_q[$];
    int               mcount = 0;
    bit               movr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit rd);
        bit acc;
        bit dq;
        rst                   = r;
        dif.ctrl_enq_valid_in = v;
        dif.data_enq_in       = d;
        dif.ctrl_deq_ready_in = rd;
        #1;
        chk("enq_ready", 32'(dif.ctrl_enq_ready_out), 32'(!r && mcount < DEPTH));
        chk("deq_valid", 32'(dif.ctrl_deq_valid_out), 32'(!r && mcount > 0));
        chk("count", 32'(dif.data_count_out), r ? 32'd0 : 32'(mcount));
        chk("overrun", 32'(dif.ctrl_overrun_out), 32'(movr));
        if (!r && mcount > 0) begin
            chk("head_data", 32'(dif.data_deq_out), 32'(exp_q[0]));
        end
        if (r) begin
            mcount = 0;
            movr   = 1'b0;
            exp_q.delete();
        end else begin
            acc = v && (mcount < DEPTH);
            dq  = rd && (mcount > 0);
            if (v && mcount == DEPTH) movr = 1'b1;
            if (acc) exp_q.push_back(d);
            mcount = mcount + int'(acc) - int'(dq);
        end
        @(negedge clk);
    endtask

    // Monitor: every completed dequeue must deliver the oldest accepted byte.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && dif.ctrl_deq_valid_out === 1'b1 && dif.ctrl_deq_ready_in === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("deq_underflow", 32'(dif.data_deq_out), 32'hFFFF_FFFF);
                end else begin
                    chk("deq_data", 32'(dif.data_deq_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int vbias;
        int rbias;
        rst                   = 1'b1;
        dif.ctrl_enq_valid_in = 1'b0;
        dif.data_enq_in       = '0;
        dif.ctrl_deq_ready_in = 1'b0;
        @(negedge clk);

        // Reset held with a pending byte: nothing may be written.
        step(1, 1, 8'hEE, 0);
        step(1, 1, 8'hEE, 0);
        step(0, 0, 8'h00, 0);
        chk("reset_count_zero", 32'(dif.data_count_out), 32'd0);

        // Single byte, one cycle latency, then consumed.
        step(0, 1, 8'hA5, 0);
        step(0, 0, 8'h00, 0);
        chk("single_data", 32'(dif.data_deq_out), 32'hA5);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Fill, overrun attempt with 0x09, drain.
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 8'(i), 0);
        step(0, 1, 8'h09, 0);
        step(0, 1, 8'h09, 0);
        chk("overrun_sticky", 32'(dif.ctrl_overrun_out), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Full with simultaneous dequeue: enqueue refused, then accepted next cycle.
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 8'(i), 0);
        step(0, 1, 8'h09, 1);
        step(0, 1, 8'h09, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Streaming through pointer wrap at steady occupancy of one.
        step(0, 1, 8'h10, 0);
        for (int i = 1; i < 20; i++) step(0, 1, 8'(8'h10 + i), 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Reset mid-operation discards contents and clears overrun.
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0);
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h55, 0);
        chk("post_reset_first", 32'(dif.data_deq_out), 32'h55);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Random traffic with shifting producer/consumer rates and rare resets.
        for (int blk = 0; blk < 12; blk++) begin
            vbias = $urandom_range(10, 90);
            rbias = $urandom_range(10, 90);
            for (int c = 0; c < 120; c++) begin
                step(($urandom_range(0, 249) == 0),
                     ($urandom_range(0, 99) < vbias),
                     8'($urandom),
                     ($urandom_range(0, 99) < rbias));
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
